// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects and formats the writeback value, then registers it for the register file.
// Optional build macro MISALIGN_TRAP_EN adds the misalign_err output and suppresses writes of misaligned loads.
module mem_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_in,
    input  logic        reg_write_in,
    input  logic [4:0]  rd_in,
    input  logic [1:0]  wb_sel_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mem_rdata_in,
    input  logic [31:0] pc_in,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_address,
    output logic        wb_write_en,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic        valid_out
);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] pc_plus4;
    logic [31:0] src_data;
    logic        is_half;
    logic        is_byte;
    logic        misalign;
    logic        write_qual;

    logic [31:0] data_d;
    logic [4:0]  addr_d;
    logic        we_d;
    logic        valid_d;
    logic        err_d;
    logic        err_q;

    always_comb begin
        load_byte = 8'h00;
        case (alu_result_in[1:0])
            2'd0:    load_byte = mem_rdata_in[7:0];
            2'd1:    load_byte = mem_rdata_in[15:8];
            2'd2:    load_byte = mem_rdata_in[23:16];
            default: load_byte = mem_rdata_in[31:24];
        endcase
    end

    // Bit 0 never participates in halfword selection, so an odd halfword address is forced aligned.
    assign load_half = alu_result_in[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];

    assign is_half = (funct3_in == F3_LH) || (funct3_in == F3_LHU);
    assign is_byte = (funct3_in == F3_LB) || (funct3_in == F3_LBU);

    always_comb begin
        load_data = mem_rdata_in;
        case (funct3_in)
            F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            F3_LH:   load_data = {{16{load_half[15]}}, load_half};
            F3_LBU:  load_data = {24'h000000, load_byte};
            F3_LHU:  load_data = {16'h0000, load_half};
            default: load_data = mem_rdata_in;
        endcase
    end

    assign pc_plus4 = pc_in + 32'd4;

    always_comb begin
        src_data = alu_result_in;
        case (wb_sel_in)
            SEL_MEM: src_data = load_data;
            SEL_PC4: src_data = pc_plus4;
            default: src_data = alu_result_in;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Undefined funct3 values behave as LW, so they trap on any nonzero word offset too.
    assign misalign = valid_in && (wb_sel_in == SEL_MEM) &&
                      ((is_half && alu_result_in[0]) ||
                       (!is_half && !is_byte && (alu_result_in[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign write_qual = valid_in && reg_write_in && (rd_in != 5'd0) && !misalign;

    // Priority: reset, then flush, then stall (hold), then load.
    always_comb begin
        data_d  = wb_data;
        addr_d  = wb_address;
        we_d    = wb_write_en;
        valid_d = valid_out;
        err_d   = err_q;
        if (reset || flush) begin
            data_d  = 32'h0000_0000;
            addr_d  = 5'd0;
            we_d    = 1'b0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (!stall) begin
            data_d  = src_data;
            addr_d  = rd_in;
            we_d    = write_qual;
            valid_d = valid_in;
            err_d   = misalign;
        end
    end

    always_ff @(posedge clk) begin
        wb_data     <= data_d;
        wb_address  <= addr_d;
        wb_write_en <= we_d;
        valid_out   <= valid_d;
        err_q       <= err_d;
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage: the driver queues hand-computed expectations,
// a monitor pops one per clock edge and compares against the registered outputs.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_in, reg_write_in;
    logic [4:0]  rd_in;
    logic [1:0]  wb_sel_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in, mem_rdata_in, pc_in;
    logic [31:0] wb_data;
    logic [4:0]  wb_address;
    logic        wb_write_en, valid_out, misalign_err;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
    assign misalign_err = 1'b0;
`endif

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .reg_write_in(reg_write_in), .rd_in(rd_in),
        .wb_sel_in(wb_sel_in), .funct3_in(funct3_in), .alu_result_in(alu_result_in),
        .mem_rdata_in(mem_rdata_in), .pc_in(pc_in),
        .wb_data(wb_data), .wb_address(wb_address), .wb_write_en(wb_write_en),
`ifdef MISALIGN_TRAP_EN
        .misalign_err(misalign_err),
`endif
        .valid_out(valid_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: {data, addr, we, valid, err}
    logic [39:0] exp_q[$];
    string       tag_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            logic [39:0] e;
            logic [39:0] a;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {wb_data, wb_address, wb_write_en, valid_out, misalign_err};
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL %s: got data=%h addr=%0d we=%b valid=%b err=%b, expected data=%h addr=%0d we=%b valid=%b err=%b",
                         t, a[39:8], a[7:3], a[2], a[1], a[0], e[39:8], e[7:3], e[2], e[1], e[0]);
            end
        end
    end

    // driver: applies one cycle of inputs and queues the output expected after the next edge
    task automatic cyc(input logic rst, input logic st, input logic fl, input logic v, input logic rw,
                       input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                       input logic [31:0] ed, input logic [4:0] ea, input logic ewe,
                       input logic ev, input logic eerr, input string tag);
        @(negedge clk);
        reset = rst; stall = st; flush = fl; valid_in = v; reg_write_in = rw;
        rd_in = rd; wb_sel_in = sel; funct3_in = f3;
        alu_result_in = alu; mem_rdata_in = mem; pc_in = pc;
        exp_q.push_back({ed, ea, ewe, ev, eerr});
        tag_q.push_back(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0; reg_write_in = 1'b0;
        rd_in = 5'd0; wb_sel_in = 2'b00; funct3_in = 3'b000;
        alu_result_in = 32'h0; mem_rdata_in = 32'h0; pc_in = 32'h0;

        //   rst st fl v rw rd  sel    f3      alu           mem           pc            exp_data      addr we v err
        cyc(1, 1, 0, 1, 1, 5'd9,  2'b00, 3'b000, 32'h1111_1111, 32'h0,        32'h0,        32'h0000_0000, 5'd0,  0, 0, 0, "reset");
        cyc(0, 0, 0, 1, 1, 5'd5,  2'b01, 3'b000, 32'h0000_0003, 32'h80FF_1234, 32'h0,        32'hFFFF_FF80, 5'd5,  1, 1, 0, "lb_off3");
        cyc(0, 0, 0, 1, 1, 5'd5,  2'b01, 3'b100, 32'h0000_0003, 32'h80FF_1234, 32'h0,        32'h0000_0080, 5'd5,  1, 1, 0, "lbu_off3");
        cyc(0, 0, 0, 1, 1, 5'd6,  2'b01, 3'b000, 32'h0000_0001, 32'h80FF_1234, 32'h0,        32'h0000_0012, 5'd6,  1, 1, 0, "lb_off1");
        cyc(0, 0, 0, 1, 1, 5'd8,  2'b01, 3'b001, 32'h0000_0002, 32'h80FF_1234, 32'h0,        32'hFFFF_80FF, 5'd8,  1, 1, 0, "lh_hi");
        cyc(0, 0, 0, 1, 1, 5'd9,  2'b01, 3'b101, 32'h0000_0000, 32'h1234_ABCD, 32'h0,        32'h0000_ABCD, 5'd9,  1, 1, 0, "lhu_lo");
        cyc(0, 0, 0, 1, 1, 5'd10, 2'b01, 3'b001, 32'h0000_0000, 32'h0000_7FFF, 32'h0,        32'h0000_7FFF, 5'd10, 1, 1, 0, "lh_pos");
        cyc(0, 0, 0, 1, 1, 5'd11, 2'b01, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 5'd11, 1, 1, 0, "lw_aligned");
        cyc(0, 0, 0, 1, 1, 5'd0,  2'b00, 3'b000, 32'h1234_5678, 32'h0,        32'h0,        32'h1234_5678, 5'd0,  0, 1, 0, "alu_rd0");
        cyc(0, 0, 0, 1, 1, 5'd1,  2'b10, 3'b000, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0000_0000, 5'd1,  1, 1, 0, "pc4_wrap");
        cyc(0, 0, 0, 1, 1, 5'd2,  2'b10, 3'b000, 32'h0,        32'h0,        32'h0000_0100, 32'h0000_0104, 5'd2,  1, 1, 0, "pc4");
        cyc(0, 0, 0, 1, 1, 5'd3,  2'b11, 3'b000, 32'hCAFE_F00D, 32'h5555_5555, 32'h0000_0200, 32'hCAFE_F00D, 5'd3,  1, 1, 0, "sel11_alu");
        cyc(0, 0, 0, 0, 1, 5'd4,  2'b00, 3'b000, 32'h0000_0055, 32'h0,        32'h0,        32'h0000_0055, 5'd4,  0, 0, 0, "invalid_no_write");
        cyc(0, 0, 0, 1, 0, 5'd4,  2'b00, 3'b000, 32'h0000_0066, 32'h0,        32'h0,        32'h0000_0066, 5'd4,  0, 1, 0, "no_regwrite");
        cyc(0, 0, 0, 1, 1, 5'd7,  2'b00, 3'b000, 32'h0000_00AA, 32'h0,        32'h0,        32'h0000_00AA, 5'd7,  1, 1, 0, "load_aa");
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 1, 1, 5'd12, 2'b00, 3'b000, 32'h0000_0999, 32'h0,   32'h0,        32'h0000_00AA, 5'd7,  1, 1, 0, "stall_hold");
        cyc(0, 1, 1, 1, 1, 5'd12, 2'b00, 3'b000, 32'h0000_0999, 32'h0,        32'h0,        32'h0000_0000, 5'd0,  0, 0, 0, "flush_over_stall");
        cyc(0, 0, 0, 1, 1, 5'd7,  2'b00, 3'b000, 32'h0000_00AA, 32'h0,        32'h0,        32'h0000_00AA, 5'd7,  1, 1, 0, "reload_aa");
        cyc(0, 1, 0, 1, 1, 5'd20, 2'b00, 3'b000, 32'h0000_0321, 32'h0,        32'h0,        32'h0000_00AA, 5'd7,  1, 1, 0, "stall_again");
        cyc(1, 1, 0, 1, 1, 5'd20, 2'b00, 3'b000, 32'h0000_0321, 32'h0,        32'h0,        32'h0000_0000, 5'd0,  0, 0, 0, "reset_mid_stall");
        cyc(0, 1, 0, 1, 1, 5'd13, 2'b00, 3'b000, 32'h0000_0077, 32'h0,        32'h0,        32'h0000_0000, 5'd0,  0, 0, 0, "post_reset_stall");
        cyc(0, 0, 0, 1, 1, 5'd13, 2'b00, 3'b000, 32'h0000_0077, 32'h0,        32'h0,        32'h0000_0077, 5'd13, 1, 1, 0, "first_load");
        cyc(0, 0, 1, 1, 1, 5'd13, 2'b00, 3'b000, 32'h0000_0077, 32'h0,        32'h0,        32'h0000_0000, 5'd0,  0, 0, 0, "flush");
        cyc(0, 0, 0, 1, 1, 5'd14, 2'b01, 3'b010, 32'h0000_1002, 32'h1122_3344, 32'h0,        32'h1122_3344, 5'd14, !TRAP, 1, TRAP, "lw_misaligned");
        cyc(0, 0, 0, 1, 1, 5'd16, 2'b01, 3'b001, 32'h0000_0003, 32'h80FF_1234, 32'h0,        32'hFFFF_80FF, 5'd16, !TRAP, 1, TRAP, "lh_odd");
        cyc(0, 0, 0, 1, 1, 5'd15, 2'b01, 3'b011, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0,        32'hA5A5_A5A5, 5'd15, 1, 1, 0, "funct3_undef_lw");
        cyc(0, 0, 0, 1, 1, 5'd0,  2'b01, 3'b100, 32'h0000_0002, 32'h00C3_0000, 32'h0,        32'h0000_00C3, 5'd0,  0, 1, 0, "lbu_rd0");
        cyc(0, 0, 0, 1, 1, 5'd17, 2'b01, 3'b000, 32'h0000_0002, 32'h0042_0000, 32'h0,        32'h0000_0042, 5'd17, 1, 1, 0, "lb_positive");

        @(negedge clk);
        valid_in = 1'b0; reg_write_in = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
- REQ-001 CLK  input  1  single clock; all state updates on rising edge.
- REQ-002 RESET  input  1  synchronous, active-high reset.
- REQ-003 STALL  input  1  hold current stage contents.
- REQ-004 FLUSH  input  1  replace next stage contents with a bubble.
- REQ-005 VALID_IN  input  1  MEM-stage instruction valid.
- REQ-006 REG_WRITE_IN  input  1  instruction writes rd.
- REQ-007 RD_IN  input  5  destination register index.
- REQ-008 WB_SEL_IN  input  2  source select: 00 ALU, 01 memory, 10 PC+4, 11 treated as ALU.
- REQ-009 FUNCT3_IN  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- REQ-010 ALU_RESULT_IN  input  32  ALU result; bits [1:0] give the load byte offset.
- REQ-011 MEM_RDATA_IN  input  32  raw aligned memory word.
- REQ-012 PC_IN  input  32  instruction PC.
- REQ-013 WB_DATA  output  32  write data to the register file IN port.
- REQ-014 WB_ADDRESS  output  5  write address to the register file INADDRESS port.
- REQ-015 WB_WRITE_EN  output  1  write enable to the register file WRITE_EN port.
- REQ-016 VALID_OUT  output  1  writeback slot holds a valid instruction.
- REQ-017 MISALIGN_ERR  output  1  misaligned load retired this cycle; present only under MISALIGN_TRAP_EN.

Function
- REQ-018 One register stage; all outputs registered; latency exactly 1 cycle from inputs to outputs.
- REQ-019 Update priority at each rising edge: RESET > FLUSH > STALL > load.
- REQ-020 Load: capture the computed write data, RD_IN and VALID_IN, and capture REG_WRITE_IN & VALID_IN as the write qualifier.
- REQ-021 STALL (no FLUSH): all outputs hold their previous values; WB_WRITE_EN holds, because repeated identical writes are harmless.
- REQ-022 FLUSH: VALID_OUT=0, WB_WRITE_EN=0, WB_DATA=0, WB_ADDRESS=0; FLUSH overrides a simultaneous STALL.
- REQ-023 WB_WRITE_EN = captured qualifier AND (captured rd != 0); a write to x0 is never issued.
- REQ-024 Memory-source extraction: byte = MEM_RDATA_IN[8*off+7:8*off] with off=ALU_RESULT_IN[1:0]; half = MEM_RDATA_IN[16*h+15:16*h] with h=ALU_RESULT_IN[1].
- REQ-025 LB/LH sign-extend to 32 bits, LBU/LHU zero-extend, LW passes the word unchanged; undefined FUNCT3 values are handled as LW.
- REQ-026 PC+4 source: PC_IN + 4 modulo 2^32, so 0xFFFFFFFC yields 0x00000000.
- REQ-027 VALID_IN=0 with REG_WRITE_IN=1 produces WB_WRITE_EN=0.

Reset
- REQ-028 Sampling RESET=1 forces WB_DATA=0, WB_ADDRESS=0, WB_WRITE_EN=0, VALID_OUT=0 and MISALIGN_ERR=0 at that edge, regardless of STALL or FLUSH.
- REQ-029 Reset asserted mid-stall discards the held instruction; after RESET deasserts, the first load occurs at the next non-stalled edge.

Configuration
- REQ-030 Macro MISALIGN_TRAP_EN: when defined, a memory-source LH/LHU with ALU_RESULT_IN[0]=1, or an LW with ALU_RESULT_IN[1:0]!=0, captures WB_WRITE_EN=0 and MISALIGN_ERR=1 for that slot, with VALID_OUT unchanged in meaning.
- REQ-031 MISALIGN_TRAP_EN undefined: MISALIGN_ERR port absent; ignore ALU_RESULT_IN[0] for halfwords and [1:0] for words, so the access is forced aligned and written normally.

Verification
- REQ-032 LB, off=3, MEM_RDATA_IN=0x80FF1234, rd=5 -> next cycle WB_DATA=0xFFFFFF80, WB_ADDRESS=5, WB_WRITE_EN=1; LBU same inputs -> 0x00000080.
- REQ-033 ALU source, rd=0, REG_WRITE_IN=1, ALU_RESULT_IN=0x12345678 -> VALID_OUT=1, WB_WRITE_EN=0.
- REQ-034 Load rd=7 with data 0xAA, then STALL=1 for 3 cycles with new inputs -> outputs stay 0xAA/7/1; FLUSH=1 together with STALL=1 -> VALID_OUT=0, WB_WRITE_EN=0 next cycle.
- REQ-035 WB_SEL_IN=10, PC_IN=0xFFFFFFFC, rd=1 -> WB_DATA=0x00000000, WB_WRITE_EN=1.
- REQ-036 LW with ALU_RESULT_IN=0x1002 -> MISALIGN_TRAP_EN defined: MISALIGN_ERR=1, WB_WRITE_EN=0; undefined: full word written, WB_WRITE_EN=1.
- REQ-037 RESET=1 asserted while stalled holding a valid write -> all outputs 0 at the following edge.
